flash_req_arbiter: RTL
======================

FLASH_REQ_ARBITER -- requirements
Module: flash_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4096: max cycles an operation may wait for llc_valid.
REQ-002 ACLK  input  1  single clock; all state on rising edge.
REQ-003 ARESETn  input  1  reset, asynchronous assert, active-low.
REQ-004 r0_req  input  1  port 0 (fetch) read request; level, held until r0_done.
REQ-005 r0_addr  input  24  port 0 byte address.
REQ-006 r0_gnt  output  1  one-cycle pulse: port 0 accepted.
REQ-007 r0_rdata  output  32  port 0 read data, valid with r0_done.
REQ-008 r0_done  output  1  one-cycle pulse: port 0 op complete.
REQ-009 r1_req  input  1  port 1 (data) request; level, held until r1_done.
REQ-010 r1_op  input  2  00 read, 01 write, 10 sector erase, 11 block erase.
REQ-011 r1_addr  input  24  port 1 byte address.
REQ-012 r1_wdata  input  32  port 1 write word.
REQ-013 r1_gnt, r1_rdata, r1_done  output  1/32/1  as port 0 equivalents.
REQ-014 err  output  1  pulses with rN_done when op aborted by timeout.
REQ-015 llc_start  output  1  level start to flash controller, held for whole op.
REQ-016 llc_address  output  24  latched op address.
REQ-017 llc_word  output  32  latched write word.
REQ-018 llc_dir  output  1  1 = program, 0 = read; on erase 1 = block, 0 = sector.
REQ-019 llc_erase  output  1  1 = erase op.
REQ-020 llc_rdata  input  32  controller read word.
REQ-021 llc_valid  input  1  controller completion strobe.
REQ-022 llc_busy  input  1  controller busy.

Function
REQ-023 FSM states IDLE, ISSUE, WAIT, DONE; exactly one active.
REQ-024 IDLE: if llc_busy=0 and any req, pick winner, latch address/word/op, pulse winner gnt, go ISSUE next cycle.
REQ-025 IDLE with llc_busy=1: no grant, no latch, stay IDLE.
REQ-026 Port 0 always issued as read (llc_dir=0, llc_erase=0).
REQ-027 ISSUE: llc_start=1; next cycle WAIT.
REQ-028 WAIT: llc_start=1; on llc_valid capture llc_rdata into winner rdata, clear llc_start same edge, go DONE.
REQ-029 WAIT: 16-bit cycle counter; reaching TIMEOUT_CYC without llc_valid clears llc_start, sets err, goes DONE.
REQ-030 DONE: pulse winner done (and err if set) one cycle, clear err, return IDLE; earliest next grant one cycle later.
REQ-031 Latency: req at cycle N with controller idle -> gnt N+1, llc_start N+1..valid cycle, done one cycle after llc_valid.
REQ-032 rN_rdata holds last captured value until next read on that port; unchanged on write/erase/timeout.
REQ-033 Requests arriving while not IDLE wait; no request is dropped while held.
REQ-034 llc_valid outside WAIT ignored.
REQ-035 Never more than one gnt or done high in same cycle.

Reset
REQ-036 ARESETn low: state IDLE; llc_start, llc_erase, llc_dir, all gnt/done, err = 0; llc_address, llc_word, r0_rdata, r1_rdata, counter = 0; RR pointer = port 0 preferred.
REQ-037 Reset mid-operation aborts immediately; no done pulse issued for the aborted op.

Configuration
REQ-038 Macro FLASH_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the port not granted last; pointer updates on each grant.
REQ-039 Macro undefined: fixed priority, port 1 wins simultaneous requests; no pointer register.

Verification
REQ-040 r0_req, addr 0x000100, llc_valid after 20 cycles with llc_rdata 0xDEADBEEF -> r0_gnt 1 cycle, llc_dir=0, r0_done one cycle after valid, r0_rdata=0xDEADBEEF.
REQ-041 r1 op=01 addr 0x001000 wdata 0x12345678 -> llc_address=0x001000, llc_word=0x12345678, llc_dir=1, llc_erase=0, r1_done, r1_rdata unchanged.
REQ-042 Both ports request continuously, 4 ops: RR_EN -> grant order 0,1,0,1; undefined -> 1,1,1,1.
REQ-043 r1 op=11, llc_valid never asserted, TIMEOUT_CYC=64 -> llc_start drops after 64 WAIT cycles, r1_done and err pulse together.
REQ-044 llc_busy=1 with r0_req high -> no r0_gnt until llc_busy=0, then gnt next cycle.
REQ-045 ARESETn low during WAIT -> all outputs zero, no done pulse; after release, held request re-granted.

Source files
------------

// File: rtl/flash_req_arbiter.sv
// Two-port flash arbiter: one op at a time to the controller; gnt the cycle after a request, done the cycle after llc_valid.
// Define FLASH_ARB_ROUND_ROBIN_EN for alternating priority on ties; otherwise port 1 always wins.
module flash_req_arbiter #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        r0_req,
  input  logic [23:0] r0_addr,
  output logic        r0_gnt,
  output logic [31:0] r0_rdata,
  output logic        r0_done,
  input  logic        r1_req,
  input  logic [1:0]  r1_op,
  input  logic [23:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic [31:0] r1_rdata,
  output logic        r1_done,
  output logic        err,
  output logic        llc_start,
  output logic [23:0] llc_address,
  output logic [31:0] llc_word,
  output logic        llc_dir,
  output logic        llc_erase,
  input  logic [31:0] llc_rdata,
  input  logic        llc_valid,
  input  logic        llc_busy
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic        winner_q, winner_d;
  logic        is_read_q, is_read_d;
  logic        start_q, start_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic        dir_q, dir_d;
  logic        erase_q, erase_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic [15:0] cnt_q, cnt_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        err_q, err_d;
  logic        pick1;
  logic        accept;

  assign accept = (state_q == S_IDLE) && !llc_busy && (r0_req || r1_req);

`ifdef FLASH_ARB_ROUND_ROBIN_EN
  // pref1_q = 1 when port 0 was granted last, so port 1 gets the next tie.
  logic pref1_q, pref1_d;
  assign pick1 = r1_req && (!r0_req || pref1_q);

  always_comb begin
    pref1_d = pref1_q;
    if (accept) pref1_d = !pick1;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) pref1_q <= 1'b0;
    else          pref1_q <= pref1_d;
  end
`else
  assign pick1 = r1_req;
`endif

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    is_read_d = is_read_q;
    start_d   = start_q;
    addr_d    = addr_q;
    word_d    = word_q;
    dir_d     = dir_q;
    erase_d   = erase_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    cnt_d     = cnt_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          winner_d = pick1;
          start_d  = 1'b1;
          cnt_d    = 16'd0;
          state_d  = S_ISSUE;
          if (pick1) begin
            addr_d    = r1_addr;
            word_d    = r1_wdata;
            dir_d     = r1_op[0];
            erase_d   = r1_op[1];
            is_read_d = (r1_op == 2'b00);
            gnt1_d    = 1'b1;
          end else begin
            addr_d    = r0_addr;
            dir_d     = 1'b0;
            erase_d   = 1'b0;
            is_read_d = 1'b1;
            gnt0_d    = 1'b1;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (llc_valid) begin
          start_d = 1'b0;
          state_d = S_DONE;
          done0_d = !winner_q;
          done1_d = winner_q;
          if (is_read_q && !winner_q) rdata0_d = llc_rdata;
          if (is_read_q && winner_q)  rdata1_d = llc_rdata;
        end else if (cnt_q == CNT_LAST) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
          done0_d = !winner_q;
          done1_d = winner_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= S_IDLE;
      winner_q  <= 1'b0;
      is_read_q <= 1'b0;
      start_q   <= 1'b0;
      addr_q    <= '0;
      word_q    <= '0;
      dir_q     <= 1'b0;
      erase_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      cnt_q     <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      is_read_q <= is_read_d;
      start_q   <= start_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      dir_q     <= dir_d;
      erase_q   <= erase_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      cnt_q     <= cnt_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err_q     <= err_d;
    end
  end

  assign r0_gnt      = gnt0_q;
  assign r1_gnt      = gnt1_q;
  assign r0_done     = done0_q;
  assign r1_done     = done1_q;
  assign r0_rdata    = rdata0_q;
  assign r1_rdata    = rdata1_q;
  assign err         = err_q;
  assign llc_start   = start_q;
  assign llc_address = addr_q;
  assign llc_word    = word_q;
  assign llc_dir     = dir_q;
  assign llc_erase   = erase_q;
endmodule
